note_lane_renderer: RTL and testbench

//  Downstream of the note shifter: takes the 10-slot visible note window and repaints the lane on the VGA adapter.
//  On each shift tick it snapshots the window, then paints ten 4x4 squares, one pixel per clock.
//  A slot holding a note is painted NOTE_COLOUR (HIT_COLOUR for slot 0, the hit zone); an empty slot is painted BG_COLOUR.

---
 rtl/note_lane_renderer_pkg.sv | 36 +++
 rtl/note_lane_renderer_slot_pixel_counter.sv | 32 +++
 rtl/note_lane_renderer.sv | 110 +++++++++++
 tb/tb_note_lane_renderer.sv | 194 +++++++++++++++++++
 4 files changed

// File: rtl/note_lane_renderer_pkg.sv
// Shared constants and types for the note lane renderer: palette, lane geometry,
// pixel record and the slot colour rule.
package note_lane_renderer_pkg;

    localparam logic [2:0] BLACK   = 3'b000;
    localparam logic [2:0] BLUE    = 3'b001;
    localparam logic [2:0] GREEN   = 3'b010;
    localparam logic [2:0] CYAN    = 3'b011;
    localparam logic [2:0] RED     = 3'b100;
    localparam logic [2:0] MAGENTA = 3'b101;
    localparam logic [2:0] YELLOW  = 3'b110;
    localparam logic [2:0] WHITE   = 3'b111;

    localparam logic [6:0] LANE_ROW     = 7'd53;
    localparam int         NUM_SLOTS    = 10;
    localparam int         SQUARE_SIZE  = 4;
    localparam int         FRAME_PIXELS = NUM_SLOTS * SQUARE_SIZE * SQUARE_SIZE;

    typedef struct packed {
        logic [7:0] x;
        logic [6:0] y;
        logic [2:0] colour;
    } pixel_t;

    // Slot 0 is the hit zone and gets its own highlight colour when occupied.
    function automatic logic [2:0] slot_colour(input logic       occupied,
                                               input logic [3:0] slot,
                                               input logic [2:0] hit_c,
                                               input logic [2:0] note_c,
                                               input logic [2:0] bg_c);
        if (!occupied)
            return bg_c;
        return (slot == 4'd0) ? hit_c : note_c;
    endfunction

endpackage

// File: rtl/note_lane_renderer_slot_pixel_counter.sv
// Frame pixel counter 0..159, decoded into slot index and pixel offset inside
// the 4x4 square (px fastest, then py, then slot).
module slot_pixel_counter
    import note_lane_renderer_pkg::*;
(
    input  logic       clk,
    input  logic       resetn,
    input  logic       clear,
    input  logic       enable,
    output logic [3:0] slot,
    output logic [1:0] px,
    output logic [1:0] py,
    output logic       last
);

    logic [7:0] cnt;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn)
            cnt <= '0;
        else if (clear)
            cnt <= '0;
        else if (enable)
            cnt <= last ? 8'd0 : cnt + 8'd1;
    end

    assign slot = cnt[7:4];
    assign py   = cnt[3:2];
    assign px   = cnt[1:0];
    assign last = (cnt == 8'(FRAME_PIXELS - 1));

endmodule

// File: rtl/note_lane_renderer.sv
// Repaints the 10-slot note lane on the VGA adapter, one pixel per clock,
// each time the note shifter signals a new window.
module note_lane_renderer
    import note_lane_renderer_pkg::*;
#(
    parameter logic [7:0] X0          = 8'd8,
    parameter logic [6:0] ROW         = LANE_ROW,
    parameter logic [7:0] PITCH       = 8'd12,
    parameter logic [2:0] NOTE_COLOUR = RED,
    parameter logic [2:0] HIT_COLOUR  = YELLOW,
    parameter logic [2:0] BG_COLOUR   = BLACK
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [9:0] notes,
    input  logic       shift_tick,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       frame_done
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_DRAW = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    // state tracks what the registered outputs currently show; the counter
    // holds the index of the pixel to be emitted at the next edge.
    logic [1:0] state, state_nxt;
    logic [9:0] snapshot;
    logic       pending;
    logic       start, emit, frame_end;
    logic [3:0] slot;
    logic [1:0] px, py;
    logic       last;
    logic [9:0] src;
    pixel_t     pix;

    slot_pixel_counter u_cnt (
        .clk    (clk),
        .resetn (resetn),
        .clear  (!emit),
        .enable (emit),
        .slot   (slot),
        .px     (px),
        .py     (py),
        .last   (last)
    );

    always_comb begin
        // Inside DRAW the counter only reads zero once pixel 159 has been emitted.
        frame_end = (state == S_DRAW) && ({slot, py, px} == 8'd0);
        start     = ((state == S_IDLE) && shift_tick) ||
                    ((state == S_DONE) && (pending || shift_tick));
        emit      = start || ((state == S_DRAW) && !frame_end);

        state_nxt = state;
        case (state)
            S_IDLE:  if (start) state_nxt = S_DRAW;
            S_DRAW:  if (frame_end) state_nxt = S_DONE;
            S_DONE:  state_nxt = start ? S_DRAW : S_IDLE;
            default: state_nxt = S_IDLE;
        endcase

        // The first pixel of a frame is emitted on the capture edge, so it reads notes directly.
        src        = start ? notes : snapshot;
        pix.x      = X0 + 8'(slot) * PITCH + 8'(px);
        pix.y      = ROW + 7'(py);
        pix.colour = slot_colour(src[4'd9 - slot], slot, HIT_COLOUR, NOTE_COLOUR, BG_COLOUR);
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state    <= S_IDLE;
            snapshot <= '0;
            pending  <= 1'b0;
        end else begin
            state <= state_nxt;
            if (start)
                snapshot <= notes;
            if (start)
                pending <= 1'b0;
            else if (shift_tick && (state != S_IDLE))
                pending <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            x          <= '0;
            y          <= '0;
            colour     <= '0;
            plot       <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            plot       <= emit;
            busy       <= (state_nxt != S_IDLE);
            frame_done <= frame_end;
            if (emit) begin
                x      <= pix.x;
                y      <= pix.y;
                colour <= pix.colour;
            end
        end
    end

endmodule

// File: tb/tb_note_lane_renderer.sv
// Randomized bench for note_lane_renderer against a time-based frame model.
module tb_note_lane_renderer;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [9:0] notes = '0;
    logic       shift_tick = 1'b0;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;
    logic       plot, busy, frame_done;

    note_lane_renderer dut (
        .clk(clk), .resetn(resetn), .notes(notes), .shift_tick(shift_tick),
        .x(x), .y(y), .colour(colour), .plot(plot), .busy(busy), .frame_done(frame_done)
    );

    always #10 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Model: a frame starts at the tick cycle T; pixels show at T+1..T+160,
    // frame_done at T+161, where the restart decision is also taken.
    int         cyc = 0;
    bit         m_active = 0;
    int         m_start = 0;
    logic [9:0] m_snap = '0;
    bit         m_pend = 0;
    logic       e_plot = 0, e_busy = 0, e_fd = 0;
    logic [17:0] e_pix = '0;
    bit         chk_zero = 0;

    int n_plot, n_hit, n_note, n_bg, fd_cnt, fd_at;

    task automatic model_next(input logic t, input logic [9:0] n);
        int  r, idx, slot;
        bit  go;
        logic [2:0] col;
        go = 0;
        if (!m_active)
            go = t;
        else if (cyc - m_start == 161) begin
            if (m_pend || t) go = 1;
            else m_active = 0;
        end else if (t)
            m_pend = 1;
        if (go) begin
            m_active = 1; m_start = cyc; m_snap = n; m_pend = 0;
        end
        e_plot = 0; e_busy = 0; e_fd = 0;
        if (m_active) begin
            r = cyc + 1 - m_start;
            e_busy = 1;
            e_fd = (r == 161);
            if (r >= 1 && r <= 160) begin
                e_plot = 1;
                idx  = r - 1;
                slot = idx / 16;
                if (!m_snap[9 - slot]) col = 3'd0;
                else if (slot == 0)    col = 3'd6;
                else                   col = 3'd4;
                e_pix = {8'(8 + slot * 12 + idx % 4), 7'(53 + (idx % 16) / 4), col};
            end
        end
    endtask

    task automatic clr_stats();
        n_plot = 0; n_hit = 0; n_note = 0; n_bg = 0; fd_cnt = 0; fd_at = -1;
    endtask

    task automatic step(input logic t, input logic [9:0] n);
        @(negedge clk);
        chk("ctl", {plot, busy, frame_done}, {e_plot, e_busy, e_fd});
        if (e_plot) chk("pix", {x, y, colour}, e_pix);
        if (chk_zero) chk("idle_xyc", {x, y, colour}, 0);
        if (plot === 1'b1) begin
            n_plot++;
            if (colour == 3'd6 && x >= 8 && x <= 11 && y >= 53 && y <= 56) n_hit++;
            else if (colour == 3'd4 && x >= 116 && x <= 119 && y >= 53 && y <= 56) n_note++;
            else if (colour == 3'd0) n_bg++;
        end
        if (frame_done === 1'b1) begin
            fd_cnt++;
            if (fd_at < 0) fd_at = cyc;
        end
        shift_tick = t;
        notes = n;
        model_next(t, n);
        cyc++;
        if (t) chk_zero = 0;
    endtask

    task automatic idle_run(input int k, input logic [9:0] n);
        for (int i = 0; i < k; i++) step(1'b0, n);
    endtask

    task automatic noisy_run(input int k);
        for (int i = 0; i < k; i++) step(1'b0, 10'($urandom));
    endtask

    int t0;

    initial begin
        #1;
        chk("rst_state", {x, y, colour, plot, busy, frame_done}, 0);
        @(negedge clk);
        resetn = 1'b1;
        chk_zero = 1;
        clr_stats();
        idle_run(50, 10'h000);
        chk("idle_plots", n_plot, 0);

        // Single frame with slots 0 and 9 occupied; notes churn every clock mid-frame.
        clr_stats();
        t0 = cyc;
        step(1'b1, 10'b1000000001);
        noisy_run(170);
        chk("plot_cnt", n_plot, 160);
        chk("hit_px", n_hit, 16);
        chk("note_px", n_note, 16);
        chk("bg_px", n_bg, 128);
        chk("fd_cnt", fd_cnt, 1);
        chk("fd_lat", fd_at - t0, 161);

        // Tick at DRAW cycle 40 with the window going all-occupied.
        clr_stats();
        step(1'b1, 10'b1000000001);
        idle_run(40, 10'b1000000001);
        step(1'b1, 10'h3FF);
        idle_run(300, 10'h3FF);
        chk("mid_fd_cnt", fd_cnt, 2);
        chk("mid_plot_cnt", n_plot, 320);
        chk("mid_hit", n_hit, 32);

        // Three ticks in one frame collapse to one extra frame.
        clr_stats();
        step(1'b1, 10'($urandom));
        noisy_run(9);   step(1'b1, 10'($urandom));
        noisy_run(39);  step(1'b1, 10'($urandom));
        noisy_run(49);  step(1'b1, 10'($urandom));
        noisy_run(300);
        chk("multi_fd_cnt", fd_cnt, 2);
        chk("multi_plot_cnt", n_plot, 320);

        // Tick landing exactly on the DONE cycle.
        clr_stats();
        step(1'b1, 10'($urandom));
        noisy_run(160);
        step(1'b1, 10'($urandom));
        noisy_run(200);
        chk("b2b_fd_cnt", fd_cnt, 2);
        chk("b2b_plot_cnt", n_plot, 320);

        // Random ticks and notes.
        for (int i = 0; i < 3000; i++)
            step(($urandom_range(0, 59) == 0), 10'($urandom));
        noisy_run(330);

        // Reset in the middle of a frame.
        step(1'b1, 10'($urandom));
        noisy_run(80);
        #2;
        resetn = 1'b0;
        shift_tick = 1'b0;
        #1;
        chk("rst_async_plot", plot, 0);
        chk("rst_async_busy", busy, 0);
        m_active = 0; m_pend = 0;
        e_plot = 0; e_busy = 0; e_fd = 0;
        idle_run(3, 10'h000);
        resetn = 1'b1;
        chk_zero = 1;
        clr_stats();
        idle_run(20, 10'h3FF);
        chk("post_rst_plots", n_plot, 0);
        step(1'b1, 10'b0100000000);
        idle_run(170, 10'h000);
        chk("post_rst_plot_cnt", n_plot, 160);
        chk("post_rst_fd_cnt", fd_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
